// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Bus bundle between the core fetch path, the test/loader port,
//               the instruction memory and the arbiter that shares it.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core fetch side
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;

    // Test / loader side
    logic              ld_req;
    logic              ld_we;
    logic              ld_lock;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_rdata;

    // Instruction memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Core stall indication while the loader holds the port
    logic              core_stall;

    // Arbiter view
    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_valid, fetch_data,
        input  ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        output ld_gnt, ld_valid, ld_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output core_stall
    );

    // Requester / memory environment view
    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_valid, fetch_data,
        output ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        input  ld_gnt, ld_valid, ld_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  core_stall
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares one instruction-memory port between core fetch and the
//               loader. Loader wins by default, fetch is forced through after
//               MAX_WAIT denied cycles, and the loader may lock the port for
//               burst loads. Responses return one cycle after grant.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    imem_arbiter_if.slave bus
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              fetch_gnt_w;
    logic              ld_gnt_w;
    logic              core_stall_w;
    logic              fetch_valid_q;
    logic              ld_valid_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic [DATA_W-1:0] ld_rdata_q;

    // State and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Arbitration, next state and starvation counter update
    always_comb begin
        fetch_gnt_w  = 1'b0;
        ld_gnt_w     = 1'b0;
        core_stall_w = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            LOCKED: begin
                // Loader owns the port; the deassert cycle is still locked.
                ld_gnt_w     = bus.ld_req;
                core_stall_w = 1'b1;
                if (!bus.ld_lock) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (bus.fetch_req && (wait_cnt_q == MAX_WAIT_C)) begin
                    fetch_gnt_w = 1'b1;
                end else if (bus.ld_req) begin
                    ld_gnt_w = 1'b1;
                end else if (bus.fetch_req) begin
                    fetch_gnt_w = 1'b1;
                end

                // A granted locking request stalls the core from this cycle on.
                if (ld_gnt_w && bus.ld_lock) begin
                    state_d      = LOCKED;
                    core_stall_w = 1'b1;
                end

                if (bus.fetch_req && !fetch_gnt_w) begin
                    wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C
                                                            : wait_cnt_q + 4'd1;
                end else begin
                    wait_cnt_d = 4'd0;
                end
            end
        endcase
    end

    // One-cycle response pipeline; data registers hold between grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            ld_valid_q    <= 1'b0;
            fetch_data_q  <= '0;
            ld_rdata_q    <= '0;
        end else begin
            fetch_valid_q <= fetch_gnt_w;
            ld_valid_q    <= ld_gnt_w;
            if (fetch_gnt_w) begin
                fetch_data_q <= bus.mem_rdata;
            end
            if (ld_gnt_w) begin
                ld_rdata_q <= bus.ld_we ? bus.ld_wdata : bus.mem_rdata;
            end
        end
    end

    // Memory port drive follows the current grant
    always_comb begin
        bus.mem_addr = '0;
        if (fetch_gnt_w) begin
            bus.mem_addr = bus.fetch_addr;
        end else if (ld_gnt_w) begin
            bus.mem_addr = bus.ld_addr;
        end
    end

    assign bus.mem_we      = ld_gnt_w & bus.ld_we;
    assign bus.mem_wdata   = bus.ld_wdata;
    assign bus.fetch_gnt   = fetch_gnt_w;
    assign bus.ld_gnt      = ld_gnt_w;
    assign bus.core_stall  = core_stall_w;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.ld_valid    = ld_valid_q;
    assign bus.ld_rdata    = ld_rdata_q;

endmodule
`default_nettype wire
